// File: rtl/instr_encode_loader.sv
// -----------------------------------------------------------------------------
// instr_encode_loader
//
// Purpose:
//   Takes symbolic instructions (op, rd, rs1, rs2, imm) over a valid/ready
//   handshake and encodes each one as a 32-bit RV32I word: add/sub/slt/or/and,
//   addi/slti/ori/andi, lw, sw, beq and jal. Each encoded word is written to
//   the instruction-memory write port at consecutive word addresses, starting
//   at 0. Used to preload programs for bring-up and boot.
//
//   Each accepted request costs two cycles: the accept edge, then one WRITE
//   cycle that drives the memory strobe. After DEPTH words the block parks in
//   FULL. Only clear or rst leave FULL; the address never wraps.
//
// Optional feature (macro IMM_CHECK_EN):
//   When defined, each accepted request is checked for an illegal op and for
//   an out-of-range or misaligned immediate. A failing request sets the sticky
//   err flag and is dropped, so no write occurs and count is unchanged.
//   When undefined, illegal ops are written as NOP (0x00000013), oversized
//   immediates are truncated to their field width, and err is tied to 0.
//
// Ports:
//   clk         in   1         rising-edge clock
//   rst         in   1         synchronous active-high reset
//   clear       in   1         synchronous restart (count/address to 0,
//                              full/err cleared); blocks acceptance
//   in_valid    in   1         request valid
//   in_ready    out  1         request can be accepted this cycle
//   in_op       in   4         0 ADD,1 SUB,2 SLT,3 OR,4 AND,5 ADDI,6 SLTI,
//                              7 ORI,8 ANDI,9 LW,10 SW,11 BEQ,12 JAL
//   in_rd       in   5         destination register
//   in_rs1      in   5         source register 1
//   in_rs2      in   5         source register 2
//   in_imm      in   32        signed byte immediate / offset
//   imem_we     out  1         write strobe, one cycle per word
//   imem_addr   out  ADDR_W    word address of the write
//   imem_wdata  out  32        encoded instruction
//   count       out  ADDR_W+1  words written since reset/clear
//   full        out  1         count == DEPTH
//   err         out  1         sticky request error (IMM_CHECK_EN only)
// -----------------------------------------------------------------------------
module instr_encode_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  // Symbolic op codes on in_op
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_SLTI = 4'd6;
  localparam logic [3:0] OP_ORI  = 4'd7;
  localparam logic [3:0] OP_ANDI = 4'd8;
  localparam logic [3:0] OP_LW   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_JAL  = 4'd12;

  // RV32I major opcodes
  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_IALU = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_inc_s;
  logic [31:0]       wdata_r;
  logic              accept_s;
  logic              req_bad_s;

  // Build the RV32I word for one request. Register fields that the format
  // does not use are left as zero, and unknown ops become a NOP.
  function automatic logic [31:0] encode_instr(
    input logic [3:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = NOP_WORD;
    case (op)
      OP_ADD:  w = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
      OP_SUB:  w = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R};
      OP_SLT:  w = {7'b0000000, rs2, rs1, 3'b010, rd, OPC_R};
      OP_OR:   w = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R};
      OP_AND:  w = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R};
      OP_ADDI: w = {imm[11:0], rs1, 3'b000, rd, OPC_IALU};
      OP_SLTI: w = {imm[11:0], rs1, 3'b010, rd, OPC_IALU};
      OP_ORI:  w = {imm[11:0], rs1, 3'b110, rd, OPC_IALU};
      OP_ANDI: w = {imm[11:0], rs1, 3'b111, rd, OPC_IALU};
      OP_LW:   w = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
      OP_SW:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
      // B-format scatters imm[12:1]; imm[0] is simply dropped
      OP_BEQ:  w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1],
                    imm[11], OPC_BR};
      // J-format scatters imm[20:1]; rs1/rs2 are not part of the word
      OP_JAL:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

`ifdef IMM_CHECK_EN
  // True when the op is known and its immediate fits the target field
  // (branch and jump offsets must also be even).
  function automatic logic req_legal(
    input logic [3:0]  op,
    input logic [31:0] imm
  );
    logic signed [31:0] simm;
    logic               ok;
    simm = imm;
    ok   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_SLT, OP_OR, OP_AND:
        ok = 1'b1;
      OP_ADDI, OP_SLTI, OP_ORI, OP_ANDI, OP_LW, OP_SW:
        ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
      OP_BEQ:
        ok = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
      OP_JAL:
        ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign req_bad_s = !req_legal(in_op, in_imm);
`else
  assign req_bad_s = 1'b0;
`endif

  // clear must block acceptance in the same cycle, so ready is not registered
  assign in_ready    = (state_r == ST_IDLE) && !clear;
  assign accept_s    = in_valid && in_ready;
  assign count_inc_s = count_r + COUNT_ONE;

  assign imem_we    = (state_r == ST_WRITE);
  assign imem_addr  = count_r[ADDR_W-1:0];
  assign imem_wdata = wdata_r;
  assign count      = count_r;
  assign full       = (state_r == ST_FULL);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; clear overrides everything, including a pending WRITE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !req_bad_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (clear) begin
          state_nxt_s = ST_IDLE;
        end else if (count_inc_s == DEPTH_C) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (clear) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Word counter (also the write address) and the encoded-word register
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_r <= '0;
      wdata_r <= 32'h0000_0000;
    end else begin
      if (accept_s && !req_bad_s) begin
        wdata_r <= encode_instr(in_op, in_rd, in_rs1, in_rs2, in_imm);
      end
      if (state_r == ST_WRITE) begin
        count_r <= count_inc_s;
      end
    end
  end

`ifdef IMM_CHECK_EN
  logic err_r;

  // Sticky error flag, set by any rejected request
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_r <= 1'b0;
    end else if (accept_s && req_bad_s) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule
